// File: rtl/inst_rom_arbiter_if.sv
// One requester port of the instruction-ROM arbiter: a request/grant pair plus a
// fixed one-cycle response. A transfer happens in any cycle where req && gnt. The
// requester holds addr stable until gnt. The response (rvalid/rdata/err) arrives
// exactly one cycle later and cannot be stalled.
interface inst_rom_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/inst_rom_arbiter.sv
// Shares one combinational instruction ROM between the IF fetch port (fixed priority)
// and a debug/loader port whose wait is bounded by MAX_WAIT lost cycles.
module inst_rom_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  inst_rom_arbiter_if.slave                if_bus,
  inst_rom_arbiter_if.slave                dbg_bus,
  output logic                             rom_ce,
  output logic [ADDR_W-1:0]                rom_addr,
  input  logic [DATA_W-1:0]                rom_inst,
  output logic [$clog2(MAX_WAIT+1)-1:0]    wait_cnt
);
  localparam int              CW          = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   MAX_CNT     = CW'(MAX_WAIT);
  localparam logic            CHIP_ENABLE = 1'b1;

  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              if_err_q, if_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic              dbg_err_q, dbg_err_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              dbg_win, if_gnt, dbg_gnt, aligned;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] word;

  always_comb begin
    dbg_win  = dbg_bus.req && (!if_bus.req || (wait_cnt_q == MAX_CNT));
    // Nothing is granted while in reset, so a reset-cycle request never produces a response.
    dbg_gnt  = !rst && dbg_win;
    if_gnt   = !rst && if_bus.req && !dbg_win;
    gnt_addr = dbg_gnt ? dbg_bus.addr : if_bus.addr;
    aligned  = (gnt_addr[1:0] == 2'b00);

    rom_ce   = ~CHIP_ENABLE;
    rom_addr = '0;
    if ((if_gnt || dbg_gnt) && aligned) begin
      rom_ce   = CHIP_ENABLE;
      rom_addr = gnt_addr;
    end
    word = aligned ? rom_inst : '0;

    if_rvalid_d  = if_gnt;
    if_err_d     = if_gnt && !aligned;
    if_rdata_d   = if_gnt ? word : if_rdata_q;
    dbg_rvalid_d = dbg_gnt;
    dbg_err_d    = dbg_gnt && !aligned;
    dbg_rdata_d  = dbg_gnt ? word : dbg_rdata_q;

    // Counts cycles a pending debug request has lost; saturates at MAX_WAIT.
    wait_cnt_d = '0;
    if (dbg_bus.req && !dbg_gnt)
      wait_cnt_d = (wait_cnt_q == MAX_CNT) ? MAX_CNT : wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q   <= '0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_err_q    <= dbg_err_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign if_bus.gnt     = if_gnt;
  assign if_bus.rvalid  = if_rvalid_q;
  assign if_bus.err     = if_err_q;
  assign if_bus.rdata   = if_rdata_q;
  assign dbg_bus.gnt    = dbg_gnt;
  assign dbg_bus.rvalid = dbg_rvalid_q;
  assign dbg_bus.err    = dbg_err_q;
  assign dbg_bus.rdata  = dbg_rdata_q;
  assign wait_cnt       = wait_cnt_q;
endmodule
